arb_word_fifo: RTL and testbench

ARB_WORD_FIFO -- requirements
Module: arb_word_fifo

---
 rtl/arb_word_fifo_pkg.sv | 19 +
 rtl/arb_word_ram.sv | 40 ++++
 rtl/arb_word_fifo.sv | 188 ++++++++++++++++++
 tb/tb_arb_word_fifo.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/arb_word_fifo_pkg.sv
// Shared definitions for the arbiter word FIFO: data widths, lost-counter
// width and the output-stage state encoding.
package arb_word_fifo_pkg;

  localparam int WORD_W = 32;
  localparam int LOST_W = 8;

  localparam logic [LOST_W-1:0] LOST_MAX = '1;
  localparam logic [LOST_W-1:0] LOST_ONE = LOST_W'(1);

  // Output stage: nothing held, a word travelling out of the RAM, or a head
  // word presented on FIFO_DATA.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_FETCH = 2'd1,
    ST_VALID = 2'd2
  } out_state_e;

endpackage

// File: rtl/arb_word_ram.sv
// Simple dual-port word RAM: one synchronous write port, one synchronous
// read port with a registered read data output. Written so synthesis maps
// it onto block RAM.
module arb_word_ram
  import arb_word_fifo_pkg::*;
#(
  parameter int DEPTH = 1024,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              i_we,
  input  logic [AW-1:0]     i_waddr,
  input  logic [WORD_W-1:0] i_wdata,
  input  logic              i_re,
  input  logic [AW-1:0]     i_raddr,
  output logic [WORD_W-1:0] o_rdata
);

  logic [WORD_W-1:0] r_mem [DEPTH];
  logic [WORD_W-1:0] r_rdata;

  // Write port.
  // NOTE: storage arrays carry no reset; resetting them would prevent block RAM inference.
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  // Read port: data appears the cycle after the read is issued and holds
  // until the next read.
  always_ff @(posedge clk) begin
    if (i_re) begin
      r_rdata <= r_mem[i_raddr];
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/arb_word_fifo.sv
// First-word-fall-through word FIFO between the round-robin arbiter and a
// downstream consumer. Words land in a block RAM; an output FSM moves them
// through the RAM read register (FETCH) into the output register (VALID).
// While a word is presented, the next one is already prefetched into the RAM
// read register, so one write and one read per cycle stream without bubbles.
module arb_word_fifo
  import arb_word_fifo_pkg::*;
#(
  parameter int DEPTH           = 1024,
  parameter int NEAR_FULL_LEVEL = 768
) (
  input  logic                     BUS_CLK,
  input  logic                     BUS_RST_N,
  input  logic                     ARB_WRITE_OUT,
  input  logic [WORD_W-1:0]        ARB_DATA_OUT,
  output logic                     ARB_READY_OUT,
  output logic                     FIFO_FULL,
  output logic                     FIFO_NEAR_FULL,
  input  logic                     FIFO_READ_NEXT,
  output logic                     FIFO_EMPTY,
  output logic [WORD_W-1:0]        FIFO_DATA,
  output logic [$clog2(DEPTH):0]   FIFO_SIZE,
  output logic [LOST_W-1:0]        LOST_COUNT
);

  localparam int AW = $clog2(DEPTH);
  localparam int SW = AW + 1;

  localparam logic [AW:0]   PTR_ONE    = (AW + 1)'(1);
  localparam logic [SW-1:0] SIZE_ONE   = SW'(1);
  localparam logic [SW-1:0] SIZE_FULL  = SW'(DEPTH);
  localparam logic [SW-1:0] SIZE_NEAR  = SW'(NEAR_FULL_LEVEL);

  // Pointers carry one extra bit so "RAM holds DEPTH words" and "RAM empty"
  // stay distinguishable.
  logic [AW:0]         r_wptr;
  logic [AW:0]         r_rptr;
  logic                r_pf_valid;
  out_state_e          r_state;
  logic [WORD_W-1:0]   r_dout;
  logic [SW-1:0]       r_size;
  logic                r_full;
  logic                r_near_full;
  logic                r_ready;
  logic [LOST_W-1:0]   r_lost;

  out_state_e          w_state_next;
  logic                w_wr;
  logic                w_rd;
  logic                w_re;
  logic                w_load;
  logic                w_pf_next;
  logic                w_out_free;
  logic                w_ram_nonempty;
  logic [SW-1:0]       w_size_next;
  logic [WORD_W-1:0]   w_rdata;

  assign w_wr           = ARB_WRITE_OUT & r_ready;
  assign w_rd           = FIFO_READ_NEXT & (r_state == ST_VALID);
  assign w_ram_nonempty = (r_wptr != r_rptr);

  arb_word_ram #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .clk     (BUS_CLK),
    .i_we    (w_wr),
    .i_waddr (r_wptr[AW-1:0]),
    .i_wdata (ARB_DATA_OUT),
    .i_re    (w_re),
    .i_raddr (r_rptr[AW-1:0]),
    .o_rdata (w_rdata)
  );

  // Output FSM next state plus RAM read / output-load control.
  // NOTE: every output of this block gets a default first so no latch is inferred.
  always_comb begin
    w_state_next = r_state;
    w_out_free   = (r_state != ST_VALID) | w_rd;
    // A prefetched word moves to the output register whenever it is free.
    w_load       = r_pf_valid & w_out_free;
    // Refill the prefetch slot when it is empty or being emptied this cycle.
    w_re         = w_ram_nonempty & (~r_pf_valid | w_load);
    w_pf_next    = w_re | (r_pf_valid & ~w_load);

    case (r_state)
      ST_EMPTY: begin
        if (w_re) begin
          w_state_next = ST_FETCH;
        end
      end
      ST_FETCH: begin
        w_state_next = ST_VALID;
      end
      ST_VALID: begin
        if (w_rd) begin
          if (w_load) begin
            w_state_next = ST_VALID;
          end else if (w_re) begin
            w_state_next = ST_FETCH;
          end else begin
            w_state_next = ST_EMPTY;
          end
        end
      end
      default: begin
        w_state_next = ST_EMPTY;
      end
    endcase
  end

  // Output FSM state register.
  // NOTE: sequential state is assigned with <= so every flop samples pre-edge values.
  always_ff @(posedge BUS_CLK) begin
    if (!BUS_RST_N) begin
      r_state <= ST_EMPTY;
    end else begin
      r_state <= w_state_next;
    end
  end

  // RAM pointers and prefetch-slot occupancy; reset drops in-flight words.
  always_ff @(posedge BUS_CLK) begin
    if (!BUS_RST_N) begin
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_pf_valid <= 1'b0;
    end else begin
      if (w_wr) begin
        r_wptr <= r_wptr + PTR_ONE;
      end
      if (w_re) begin
        r_rptr <= r_rptr + PTR_ONE;
      end
      r_pf_valid <= w_pf_next;
    end
  end

  // Output data register; its value while empty is don't-care.
  always_ff @(posedge BUS_CLK) begin
    if (w_load) begin
      r_dout <= w_rdata;
    end
  end

  // Total occupancy: RAM words, the prefetched word and the presented word.
  always_comb begin
    w_size_next = r_size;
    case ({w_wr, w_rd})
      2'b10:   w_size_next = r_size + SIZE_ONE;
      2'b01:   w_size_next = r_size - SIZE_ONE;
      default: w_size_next = r_size;
    endcase
  end

  // Registered status flags, all derived from the post-edge occupancy.
  always_ff @(posedge BUS_CLK) begin
    if (!BUS_RST_N) begin
      r_size      <= '0;
      r_full      <= 1'b0;
      r_near_full <= 1'b0;
      r_ready     <= 1'b0;
    end else begin
      r_size      <= w_size_next;
      r_full      <= (w_size_next == SIZE_FULL);
      r_near_full <= (w_size_next >= SIZE_NEAR);
      r_ready     <= (w_size_next != SIZE_FULL);
    end
  end

  // Saturating count of writes dropped while full.
  always_ff @(posedge BUS_CLK) begin
    if (!BUS_RST_N) begin
      r_lost <= '0;
    end else if (ARB_WRITE_OUT && r_full && (r_lost != LOST_MAX)) begin
      r_lost <= r_lost + LOST_ONE;
    end
  end

  assign ARB_READY_OUT  = r_ready;
  assign FIFO_FULL      = r_full;
  assign FIFO_NEAR_FULL = r_near_full;
  assign FIFO_EMPTY     = (r_state != ST_VALID);
  assign FIFO_DATA      = r_dout;
  assign FIFO_SIZE      = r_size;
  assign LOST_COUNT     = r_lost;

endmodule

// File: tb/tb_arb_word_fifo.sv
// Bench for arb_word_fifo (DEPTH=16, NEAR_FULL_LEVEL=12). A queue-based
// reference model tracks accepted words; a negedge monitor compares status
// outputs every cycle and the head word whenever the DUT presents one.
module tb_arb_word_fifo;

  localparam int DEPTH = 16;
  localparam int NFL   = 12;
  localparam int SW    = $clog2(DEPTH) + 1;

  logic          clk;
  logic          rst_n;
  logic          wr;
  logic [31:0]   wdata;
  logic          ready;
  logic          full;
  logic          near_full;
  logic          rd;
  logic          empty;
  logic [31:0]   rdata;
  logic [SW-1:0] size;
  logic [7:0]    lost;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  logic [31:0] m_q[$];
  int          m_lost  = 0;
  bit          m_ready = 0;
  bit          m_init  = 0;
  int          stall   = 0;

  arb_word_fifo #(
    .DEPTH           (DEPTH),
    .NEAR_FULL_LEVEL (NFL)
  ) dut (
    .BUS_CLK        (clk),
    .BUS_RST_N      (rst_n),
    .ARB_WRITE_OUT  (wr),
    .ARB_DATA_OUT   (wdata),
    .ARB_READY_OUT  (ready),
    .FIFO_FULL      (full),
    .FIFO_NEAR_FULL (near_full),
    .FIFO_READ_NEXT (rd),
    .FIFO_EMPTY     (empty),
    .FIFO_DATA      (rdata),
    .FIFO_SIZE      (size),
    .LOST_COUNT     (lost)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Advance one clock; inputs change 1 ns after the rising edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int n);
    rst_n = 1'b0;
    wr    = 1'b0;
    rd    = 1'b0;
    repeat (n) cyc();
    rst_n = 1'b1;
    cyc();
  endtask

  // Monitor: at the falling edge, compare outputs against the model, then
  // fold the handshakes of the coming rising edge into the model.
  always @(negedge clk) begin
    bit pre_ready;
    bit pre_full;
    if (m_init) begin
      check("size", 64'(size), 64'(m_q.size()));
      check("full", 64'(full), 64'(m_q.size() == DEPTH));
      check("near_full", 64'(near_full), 64'(m_q.size() >= NFL));
      check("ready", 64'(ready), 64'(m_ready));
      check("lost", 64'(lost), 64'(m_lost));
      if (m_q.size() == 0) begin
        check("empty_when_model_empty", 64'(empty), 64'd1);
      end else begin
        if (!empty) check("head_data", 64'(rdata), 64'(m_q[0]));
        if (empty) stall++;
        else stall = 0;
        check("head_latency_within_2", 64'(stall <= 2), 64'd1);
        if (stall > 2) stall = 0;
      end
    end

    if (!rst_n) begin
      m_q.delete();
      m_lost  = 0;
      m_ready = 0;
      m_init  = 1;
      stall   = 0;
    end else if (m_init) begin
      pre_ready = m_ready;
      pre_full  = (m_q.size() == DEPTH);
      if (rd && !empty && m_q.size() != 0) void'(m_q.pop_front());
      if (wr) begin
        if (pre_ready) m_q.push_back(wdata);
        else if (pre_full && m_lost < 255) m_lost++;
      end
      m_ready = (m_q.size() < DEPTH);
    end
  end

  // Watchdog
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [SW-1:0] snap;
    int gaps;
    rst_n = 1'b0;
    wr    = 1'b0;
    rd    = 1'b0;
    wdata = '0;

    // Reset state and single-word latency
    do_reset(3);
    check("reset_empty", 64'(empty), 64'd1);
    check("reset_size", 64'(size), 64'd0);
    check("ready_after_release", 64'(ready), 64'd1);
    wr = 1'b1; wdata = 32'hDEADBEEF;
    cyc();
    wr = 1'b0;
    check("single_size", 64'(size), 64'd1);
    check("single_empty_edge1", 64'(empty), 64'd1);
    cyc();
    check("single_empty_edge2", 64'(empty), 64'd1);
    cyc();
    check("single_empty_fall", 64'(empty), 64'd0);
    check("single_data", 64'(rdata), 64'hDEADBEEF);
    rd = 1'b1;
    cyc();
    rd = 1'b0;
    check("single_drained", 64'(empty), 64'd1);

    // Fill to full, overflow by three, read back in order
    do_reset(2);
    for (int i = 0; i < 19; i++) begin
      wr = 1'b1; wdata = 32'(i);
      cyc();
      if (i == 10) check("near_full_before_12", 64'(near_full), 64'd0);
      if (i == 11) check("near_full_at_12", 64'(near_full), 64'd1);
      if (i == 14) check("full_before_16", 64'(full), 64'd0);
      if (i == 15) begin
        check("full_at_16", 64'(full), 64'd1);
        check("ready_low_at_16", 64'(ready), 64'd0);
      end
    end
    wr = 1'b0;
    check("lost_3", 64'(lost), 64'd3);
    rd = 1'b1;
    repeat (22) cyc();
    rd = 1'b0;
    check("fill_drained_size", 64'(size), 64'd0);

    // Streaming: one write and one read every cycle
    do_reset(2);
    gaps = 0;
    snap = '0;
    for (int i = 0; i < 1000; i++) begin
      wr = 1'b1; wdata = 32'(i); rd = 1'b1;
      cyc();
      if (i >= 4 && empty) gaps++;
      if (i == 10) snap = size;
    end
    check("stream_size_constant", 64'(size), 64'(snap));
    check("stream_no_gaps", 64'(gaps), 64'd0);
    check("stream_lost_zero", 64'(lost), 64'd0);
    wr = 1'b0;
    repeat (8) cyc();
    rd = 1'b0;

    // Lost-count saturation
    do_reset(2);
    for (int i = 0; i < DEPTH + 300; i++) begin
      wr = 1'b1; wdata = 32'hA000_0000 + 32'(i);
      cyc();
    end
    wr = 1'b0;
    check("lost_saturated", 64'(lost), 64'd255);
    rd = 1'b1;
    repeat (22) cyc();
    rd = 1'b0;

    // Random traffic with pointer wrap
    do_reset(2);
    for (int i = 0; i < 1500; i++) begin
      wr    = ($urandom_range(0, 99) < 60);
      wdata = $urandom;
      rd    = ($urandom_range(0, 99) < 50);
      cyc();
    end
    wr = 1'b0;
    rd = 1'b1;
    repeat (24) cyc();
    rd = 1'b0;

    // Reset mid-operation with a fetch in flight
    do_reset(2);
    for (int i = 0; i < 10; i++) begin
      wr = 1'b1; wdata = 32'h5500 + 32'(i);
      cyc();
    end
    wr = 1'b0; rd = 1'b1;
    cyc();
    do_reset(2);
    check("midreset_empty", 64'(empty), 64'd1);
    check("midreset_size", 64'(size), 64'd0);
    wr = 1'b1; wdata = 32'hCAFEF00D;
    cyc();
    wr = 1'b0;
    repeat (2) cyc();
    check("after_reset_empty", 64'(empty), 64'd0);
    check("after_reset_data", 64'(rdata), 64'hCAFEF00D);
    check("after_reset_size", 64'(size), 64'd1);
    rd = 1'b1;
    repeat (3) cyc();
    rd = 1'b0;
    cyc();

    check("model_queue_drained", 64'(m_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
